// File: rtl/dense_classifier_pkg.sv
// Shared constants for the dense classifier: Q8.8 weights/biases, dimensions, FSM type.
// Weights are read combinationally by the top level, indexed by output and input counters.
package data16_10;
  localparam int N_IN      = 16;
  localparam int N_OUT     = 10;
  localparam int DW        = 16;
  localparam int FRAC_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } cls_state_t;

  localparam logic signed [15:0] clsBiases [N_OUT] = '{
    16'sd100, -16'sd200, 16'sd50, 16'sh8000, 16'sd32000,
    16'sd0, -16'sd1000, 16'sd500, -16'sd32000, 16'sd32000
  };

  localparam logic signed [15:0] clsWeights [N_OUT][N_IN] = '{
    '{16'sd64, -16'sd32, 16'sd16, 16'sd8, -16'sd8, 16'sd32, -16'sd64, 16'sd0, 16'sd12, -16'sd12, 16'sd20, -16'sd20, 16'sd4, -16'sd4, 16'sd24, -16'sd24},
    '{-16'sd256, 16'sd256, -16'sd128, 16'sd128, 16'sd1, -16'sd1, 16'sd2, -16'sd2, 16'sd3, -16'sd3, 16'sd5, -16'sd5, 16'sd7, -16'sd7, 16'sd9, -16'sd9},
    '{16'sd128, 16'sd128, 16'sd128, 16'sd10, 16'sd128, 16'sd128, 16'sd128, 16'sd128, 16'sd128, 16'sd128, 16'sd128, 16'sd128, 16'sd128, 16'sd128, 16'sd128, 16'sd128},
    '{-16'sd100, 16'sd50, -16'sd25, -16'sd300, 16'sd10, 16'sd20, 16'sd30, 16'sd40, -16'sd50, -16'sd60, 16'sd70, 16'sd80, -16'sd90, 16'sd100, -16'sd110, 16'sd120},
    '{16'sd1, -16'sd1, 16'sd2, 16'sd767, -16'sd2, 16'sd3, -16'sd3, 16'sd4, -16'sd4, 16'sd5, -16'sd5, 16'sd6, -16'sd6, 16'sd7, -16'sd7, 16'sd0},
    '{16'sd200, 16'sd200, 16'sd200, -16'sd50, 16'sd200, 16'sd200, 16'sd200, 16'sd200, 16'sd200, 16'sd200, 16'sd200, 16'sd200, 16'sd200, 16'sd200, 16'sd200, 16'sd200},
    '{16'sd300, -16'sd300, 16'sd300, -16'sd300, 16'sd300, -16'sd300, 16'sd300, -16'sd300, 16'sd300, -16'sd300, 16'sd300, -16'sd300, 16'sd300, -16'sd300, 16'sd300, -16'sd300},
    '{-16'sd150, -16'sd150, -16'sd150, -16'sd150, -16'sd150, -16'sd150, -16'sd150, -16'sd150, -16'sd150, -16'sd150, -16'sd150, -16'sd150, -16'sd150, -16'sd150, -16'sd150, -16'sd150},
    '{16'sd512, -16'sd512, 16'sd256, -16'sd256, 16'sd128, -16'sd128, 16'sd64, -16'sd64, 16'sd32, -16'sd32, 16'sd16, -16'sd16, 16'sd8, -16'sd8, 16'sd4, -16'sd4},
    '{16'sd10, 16'sd20, 16'sd30, 16'sd1000, -16'sd40, -16'sd50, 16'sd60, 16'sd70, -16'sd80, 16'sd90, -16'sd100, 16'sd110, -16'sd120, 16'sd130, -16'sd140, 16'sd150}
  };
endpackage

// File: rtl/dense_classifier_mac.sv
// Single MAC with bias preload and saturating rescale; sat_out reflects the value being
// written this cycle (combinational from the next accumulator), no backpressure.
module mac_sat_unit #(
  parameter int DW        = data16_10::DW,
  parameter int FRAC_BITS = data16_10::FRAC_BITS,
  parameter int AW        = 2*DW+5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 first,
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] w,
  input  logic signed [DW-1:0] bias,
  output logic signed [DW-1:0] sat_out
);
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext, bias_ext, bias_sh, shifted;

  always_comb begin
    prod     = x * w;
    prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
    bias_ext = {{(AW-DW){bias[DW-1]}}, bias};
    bias_sh  = bias_ext <<< FRAC_BITS;
    acc_d    = acc_q;
    if (en) acc_d = (first ? bias_sh : acc_q) + prod_ext;
    // Arithmetic shift floors toward -inf before clamping to the DW range.
    shifted  = acc_d >>> FRAC_BITS;
    if (shifted > MAXV)      sat_out = MAXV[DW-1:0];
    else if (shifted < MINV) sat_out = MINV[DW-1:0];
    else                     sat_out = shifted[DW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end
endmodule

// File: rtl/dense_classifier.sv
// 10-way dense classifier: one MAC per cycle, 160 MAC cycles then DONE holds the result.
// in_ready only in IDLE or DONE with out_ready; vectors offered otherwise are dropped and flag overrun.
module dense_classifier #(
  parameter int N_IN      = data16_10::N_IN,
  parameter int N_OUT     = data16_10::N_OUT,
  parameter int DW        = data16_10::DW,
  parameter int FRAC_BITS = data16_10::FRAC_BITS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [N_IN-1:0][DW-1:0]     in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [3:0]                  out_class,
  output logic signed [DW-1:0]        out_score,
  output logic [N_OUT-1:0][DW-1:0]    out_logits,
  output logic                        overrun
);
  import data16_10::*;

  localparam int IW = $clog2(N_IN);

  cls_state_t               state_q, state_d;
  logic [N_IN-1:0][DW-1:0]  x_q, x_d;
  logic [IW-1:0]            i_q, i_d;
  logic [3:0]               o_q, o_d;
  logic [N_OUT-1:0][DW-1:0] work_q, work_d, logits_q, logits_d;
  logic signed [DW-1:0]     best_q, best_d, score_q, score_d;
  logic [3:0]               best_idx_q, best_idx_d, class_q, class_d;
  logic                     overrun_q, overrun_d;
  logic                     mac_en, mac_first, accept;
  logic signed [DW-1:0]     x_cur, w_cur, b_cur, sat_logit;

  assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == DONE);
  assign out_class  = class_q;
  assign out_score  = score_q;
  assign out_logits = logits_q;
  assign overrun    = overrun_q;

  assign x_cur = x_q[i_q];
  assign w_cur = clsWeights[o_q][i_q];
  assign b_cur = clsBiases[o_q];

  mac_sat_unit #(.DW(DW), .FRAC_BITS(FRAC_BITS)) u_mac (
    .clk     (clk),
    .reset   (reset),
    .en      (mac_en),
    .first   (mac_first),
    .x       (x_cur),
    .w       (w_cur),
    .bias    (b_cur),
    .sat_out (sat_logit)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    i_d        = i_q;
    o_d        = o_q;
    work_d     = work_q;
    logits_d   = logits_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    class_d    = class_q;
    score_d    = score_q;
    mac_en     = 1'b0;
    mac_first  = 1'b0;
    overrun_d  = overrun_q | (in_valid & ~in_ready);

    if (accept) begin
      x_d     = in_data;
      i_d     = '0;
      o_d     = '0;
      state_d = MAC;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end

    if (state_q == MAC) begin
      mac_en    = 1'b1;
      mac_first = (i_q == '0);
      if (i_q == IW'(N_IN-1)) begin
        work_d[o_q] = sat_logit;
        // Strict compare keeps the lowest index on ties.
        if (o_q == '0 || sat_logit > best_q) begin
          best_d     = sat_logit;
          best_idx_d = o_q;
        end
        i_d = '0;
        o_d = o_q + 4'd1;
        if (o_q == 4'(N_OUT-1)) begin
          state_d  = DONE;
          logits_d = work_d;
          class_d  = best_idx_d;
          score_d  = best_d;
        end
      end else begin
        i_d = i_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      i_q        <= '0;
      o_q        <= '0;
      work_q     <= '0;
      logits_q   <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
      score_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      i_q        <= i_d;
      o_q        <= o_d;
      work_q     <= work_d;
      logits_q   <= logits_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      class_q    <= class_d;
      score_q    <= score_d;
      overrun_q  <= overrun_d;
    end
  end
endmodule

// File: tb/tb_dense_classifier.sv
// Scoreboarded bench for dense_classifier: golden logits/argmax queued at accept, checked at handshake.
module tb_dense_classifier;
  import data16_10::*;

  typedef logic [N_IN-1:0][DW-1:0] vec_t;
  typedef struct packed {
    logic [3:0]              cls;
    logic [15:0]             score;
    logic [N_OUT-1:0][15:0]  lg;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       in_valid;
  vec_t                       in_data;
  logic                       in_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [3:0]                 out_class;
  logic signed [DW-1:0]       out_score;
  logic [N_OUT-1:0][DW-1:0]   out_logits;
  logic                       overrun;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  longint acc_cyc  = 0;
  exp_t   sb[$];

  dense_classifier dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_score  (out_score),
    .out_logits (out_logits),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t golden(input vec_t v);
    exp_t   e;
    longint acc, lg, best;
    e    = '0;
    best = 0;
    for (int o = 0; o < N_OUT; o++) begin
      acc = longint'(clsBiases[o]) * 256;
      for (int i = 0; i < N_IN; i++)
        acc += longint'($signed(v[i])) * longint'(clsWeights[o][i]);
      lg = acc >>> FRAC_BITS;
      if (lg > 32767)  lg = 32767;
      if (lg < -32768) lg = -32768;
      e.lg[o] = lg[15:0];
      if (o == 0 || lg > best) begin
        best  = lg;
        e.cls = 4'(o);
      end
    end
    e.score = best[15:0];
    return e;
  endfunction

  // Handshake monitor: pops one expected result per consumed output.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) check_val("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        check_val("class", out_class, e.cls);
        check_val("score", out_score, $signed(e.score));
        for (int k = 0; k < N_OUT; k++)
          check_val($sformatf("logit%0d", k), $signed(out_logits[k]), $signed(e.lg[k]));
      end
    end
  end

  task automatic accept_vec(input vec_t v);
    int w = 0;
    while (!in_ready && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) check_val("accept_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk);
    sb.push_back(golden(v));
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    for (int k = 0; k < N_IN; k++) in_data[k] = 16'($urandom);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    check_val(tag, out_valid ? (cyc - acc_cyc) : -1, N_IN * N_OUT);
  endtask

  task automatic rand_vec(output vec_t v);
    for (int k = 0; k < N_IN; k++) v[k] = 16'(int'($urandom_range(0, 4000)) - 2000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v, v2, vb, vc;
    int   ready_hi, vcount, unstable;
    exp_t e;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    #12;
    check_val("rst_valid", out_valid, 0);
    check_val("rst_class", out_class, 0);
    check_val("rst_score", out_score, 0);
    check_val("rst_logits_or", |out_logits, 0);
    check_val("rst_overrun", overrun, 0);
    check_val("rst_ready", in_ready, 1);
    reset = 1'b1;
    @(posedge clk); #1;

    // Zero, one-hot and saturating vectors
    v = '0;
    accept_vec(v); wait_valid("lat_zero"); @(posedge clk); #1;
    v = '0; v[3] = 16'd256;
    accept_vec(v); wait_valid("lat_onehot"); @(posedge clk); #1;
    for (int k = 0; k < N_IN; k++) v[k] = 16'd32767;
    accept_vec(v); wait_valid("lat_sat"); @(posedge clk); #1;

    // Overrun during MAC
    rand_vec(v); rand_vec(v2);
    accept_vec(v);
    ready_hi = 0;
    for (int k = 1; k <= 150; k++) begin
      if (in_ready) ready_hi++;
      if (k == 50) begin in_valid = 1'b1; in_data = v2; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_val("ready_in_mac", ready_hi, 0);
    check_val("overrun_set", overrun, 1);
    wait_valid("lat_ovr"); @(posedge clk); #1;
    check_val("overrun_sticky", overrun, 1);

    // Reset mid-MAC discards the result
    accept_vec(v);
    repeat (80) @(posedge clk);
    #3; reset = 1'b0; #1;
    check_val("mid_rst_valid", out_valid, 0);
    check_val("mid_rst_class", out_class, 0);
    check_val("mid_rst_score", out_score, 0);
    check_val("mid_rst_logits_or", |out_logits, 0);
    check_val("mid_rst_overrun", overrun, 0);
    sb.delete();
    #3; reset = 1'b1;
    check_val("rdy_after_rst", in_ready, 1);
    vcount = 0;
    repeat (300) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check_val("no_valid_after_rst", vcount, 0);
    @(posedge clk); #1;

    // Backpressure hold then back-to-back accept
    out_ready = 1'b0;
    rand_vec(v); rand_vec(vb); rand_vec(vc);
    accept_vec(v); wait_valid("lat_bp");
    unstable = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1) unstable++;
    end
    check_val("hold_valid", unstable, 0);
    e = golden(v);
    check_val("hold_class", out_class, e.cls);
    check_val("hold_score", out_score, $signed(e.score));
    for (int k = 0; k < N_OUT; k++)
      check_val($sformatf("hold_logit%0d", k), $signed(out_logits[k]), $signed(e.lg[k]));
    out_ready = 1'b1; #1;
    check_val("b2b_ready", in_ready, 1);
    accept_vec(vb);
    check_val("b2b_no_overrun", overrun, 0);
    check_val("b2b_busy", out_valid, 0);
    wait_valid("lat_b2b"); @(posedge clk); #1;

    // Vector offered in DONE without out_ready is dropped
    out_ready = 1'b0;
    accept_vec(vc); wait_valid("lat_c");
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = v2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("done_overrun", overrun, 1);
    check_val("done_still_valid", out_valid, 1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("back_to_idle", out_valid, 0);
    check_val("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
